// File: rtl/count_evt_pkg.sv
// Shared encodings and widths for the counter event logger.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: event type codes, event/stamp widths, and the packed FIFO entry type.
package count_evt_pkg;

  localparam int EVT_W   = 2;
  localparam int STAMP_W = 8;

  // Event type codes; EVT_NONE is never written into the FIFO.
  localparam logic [EVT_W-1:0] EVT_NONE      = 2'b00;
  localparam logic [EVT_W-1:0] EVT_WRAP_UP   = 2'b01;
  localparam logic [EVT_W-1:0] EVT_WRAP_DOWN = 2'b10;
  localparam logic [EVT_W-1:0] EVT_JUMP      = 2'b11;

  // One FIFO entry: event type in the upper bits, timestamp below.
  typedef struct packed {
    logic [EVT_W-1:0]   typ;
    logic [STAMP_W-1:0] stamp;
  } evt_t;

endpackage

// File: rtl/count_evt_fifo.sv
// Show-ahead FIFO holding logged events; head data is combinational from storage.
// Latency: a push is visible at the head the cycle after the push edge.
// Backpressure: push when full is accepted only alongside a pop; otherwise ignored.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset (flushes contents)
//   push, push_dat      write request and data
//   pop                 read request (ignored when empty)
//   head_dat            head entry, forced to 0 when empty
//   full, empty, level  occupancy status
module count_evt_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign level   = count;
  assign pop_ok  = pop && !empty;
  // A full FIFO frees the head slot on a pop in the same edge, so the write can land.
  assign push_ok = push && (!full || pop_ok);

  assign head_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: unread slots are masked by the empty check.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/count_event_logger.sv
// Watches an upstream counter and logs wrap/jump events with a cycle timestamp.
// Latency: event at edge N is at the FIFO head (evt_valid) after edge N when it was empty.
// Backpressure: evt_valid/evt_ready; events arriving while full are dropped, sticky overflow.
//
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   cnt_in, cnt_mode       observed counter value and its direction (1 = up)
//   log_en                 0 discards detected events
//   evt_valid, evt_ready   head handshake
//   evt_type, evt_stamp    head entry (0 when evt_valid=0)
//   overflow               sticky drop flag, cleared by reset only
//   level                  FIFO occupancy
module count_event_logger
  import count_evt_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CNT_W-1:0]         cnt_in,
  input  logic                     cnt_mode,
  input  logic                     log_en,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [EVT_W-1:0]         evt_type,
  output logic [STAMP_W-1:0]       evt_stamp,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]   prev_cnt;
  logic               prev_vld;
  logic [STAMP_W-1:0] stamp;
  logic               ovf;

  logic [EVT_W-1:0]   evt_kind;
  logic               is_hold;
  logic               is_step;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  evt_t               push_dat;
  evt_t               head;

  // Classify the transition prev_cnt -> cnt_in. Wraps are checked before the
  // generic step test because an up-wrap is also a +1 step modulo 2^CNT_W.
  always_comb begin
    evt_kind = EVT_NONE;
    is_hold  = (cnt_in == prev_cnt);
    is_step  = cnt_mode ? (cnt_in == prev_cnt + CNT_W'(1))
                        : (cnt_in == prev_cnt - CNT_W'(1));
    if (cnt_mode && prev_cnt == CNT_MAX && cnt_in == '0)
      evt_kind = EVT_WRAP_UP;
    else if (!cnt_mode && prev_cnt == '0 && cnt_in == CNT_MAX)
      evt_kind = EVT_WRAP_DOWN;
    else if (!is_hold && !is_step)
      evt_kind = EVT_JUMP;
  end

  // prev_vld gates detection so the first sample after reset never compares
  // against a stale prev_cnt.
  assign push           = !rst && prev_vld && log_en && (evt_kind != EVT_NONE);
  assign push_dat.typ   = evt_kind;
  assign push_dat.stamp = stamp;
  assign pop            = evt_valid && evt_ready;

  always_ff @(posedge clk) begin
    prev_cnt <= cnt_in;
    if (rst) begin
      prev_vld <= 1'b0;
      stamp    <= '0;
      ovf      <= 1'b0;
    end else begin
      prev_vld <= 1'b1;
      stamp    <= stamp + STAMP_W'(1);
      if (push && full && !pop) ovf <= 1'b1;
    end
  end

  count_evt_fifo #(
    .WIDTH ($bits(evt_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head),
    .full     (full),
    .empty    (empty),
    .level    (level)
  );

  // head is already zero when empty, so type/stamp read 0 while not valid.
  assign evt_valid = !empty;
  assign evt_type  = head.typ;
  assign evt_stamp = head.stamp;
  assign overflow  = ovf;

endmodule

// File: tb/tb_count_event_logger.sv
module tb_count_event_logger;

  logic       clk;
  logic       rst;
  logic [3:0] cnt_in;
  logic       cnt_mode;
  logic       log_en;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_type;
  logic [7:0] evt_stamp;
  logic       overflow;
  logic [2:0] level;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] tcnt;
  logic [7:0] exp_s;
  logic [7:0] sq [6];
  logic [3:0] seq4 [4] = '{4'd2, 4'd7, 4'd12, 4'd1};
  logic [3:0] seq6 [6] = '{4'd11, 4'd4, 4'd9, 4'd14, 4'd3, 4'd8};
  logic [3:0] seq3 [3] = '{4'd1, 4'd12, 4'd5};

  count_event_logger #(.CNT_W(4), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cnt_in    (cnt_in),
    .cnt_mode  (cnt_mode),
    .log_en    (log_en),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_type  (evt_type),
    .evt_stamp (evt_stamp),
    .overflow  (overflow),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge; outputs are sampled 1 time unit later. tcnt tracks the
  // stamp value the DUT should hold after this edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (rst) tcnt = 8'd0;
    else     tcnt = tcnt + 8'd1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; cnt_in = 4'd0; cnt_mode = 1'b1; log_en = 1'b1; evt_ready = 1'b1;
    tcnt = 8'd0;
    step(); step();
    chk("rst_level", 32'(level), 0);
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_type", 32'(evt_type), 0);
    chk("rst_stamp", 32'(evt_stamp), 0);
    rst = 1'b0;

    // Up-count 0..15 then wrap to 0.
    cnt_in = 4'd0; step();
    for (int v = 1; v <= 15; v++) begin
      cnt_in = 4'(v); step();
    end
    chk("up_no_evt_level", 32'(level), 0);
    chk("up_no_evt_valid", 32'(evt_valid), 0);
    exp_s = tcnt;
    cnt_in = 4'd0; step();
    chk("wrapup_valid", 32'(evt_valid), 1);
    chk("wrapup_type", 32'(evt_type), 1);
    chk("wrapup_stamp", 32'(evt_stamp), 32'(exp_s));
    chk("wrapup_stamp_abs", 32'(evt_stamp), 16);
    step();
    chk("wrapup_single_level", 32'(level), 0);
    chk("idle_valid", 32'(evt_valid), 0);
    chk("idle_type_zero", 32'(evt_type), 0);
    chk("idle_stamp_zero", 32'(evt_stamp), 0);

    // Down-count wrap 0 -> 15, then step down to 5 and hold.
    cnt_mode = 1'b0;
    exp_s = tcnt;
    cnt_in = 4'd15; step();
    chk("wrapdn_valid", 32'(evt_valid), 1);
    chk("wrapdn_type", 32'(evt_type), 2);
    chk("wrapdn_stamp", 32'(evt_stamp), 32'(exp_s));
    for (int v = 14; v >= 5; v--) begin
      cnt_in = 4'(v); step();
    end
    chk("down_steps_level", 32'(level), 0);
    repeat (3) step();
    chk("hold_level", 32'(level), 0);
    chk("hold_valid", 32'(evt_valid), 0);

    // Jump 3 -> 9 in up mode (5 -> 3 discarded with log_en=0).
    cnt_mode = 1'b1; log_en = 1'b0;
    cnt_in = 4'd3; step();
    chk("logen_off_level", 32'(level), 0);
    log_en = 1'b1;
    exp_s = tcnt;
    cnt_in = 4'd9; step();
    chk("jump_valid", 32'(evt_valid), 1);
    chk("jump_type", 32'(evt_type), 3);
    chk("jump_stamp", 32'(evt_stamp), 32'(exp_s));
    cnt_in = 4'd10; step();
    chk("jump_popped", 32'(evt_valid), 0);

    // Fill to full, then push and pop at the same edge.
    evt_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sq[i] = tcnt; cnt_in = seq4[i]; step();
    end
    chk("fill_level", 32'(level), 4);
    chk("fill_overflow", 32'(overflow), 0);
    chk("fill_head_stable", 32'(evt_stamp), 32'(sq[0]));
    evt_ready = 1'b1;
    sq[4] = tcnt; cnt_in = 4'd6; step();
    chk("pushpop_level", 32'(level), 4);
    chk("pushpop_overflow", 32'(overflow), 0);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("drain_a_valid%0d", i), 32'(evt_valid), 1);
      chk($sformatf("drain_a_stamp%0d", i), 32'(evt_stamp), 32'(sq[i]));
      step();
    end
    chk("drain_a_level", 32'(level), 0);
    chk("drain_a_valid", 32'(evt_valid), 0);

    // Six jumps into a stalled FIFO: two dropped, overflow set.
    evt_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sq[i] = tcnt; cnt_in = seq6[i]; step();
    end
    chk("ovf_level", 32'(level), 4);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_head_stable", 32'(evt_stamp), 32'(sq[0]));
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_b_type%0d", i), 32'(evt_type), 3);
      chk($sformatf("drain_b_stamp%0d", i), 32'(evt_stamp), 32'(sq[i]));
      step();
    end
    chk("drain_b_level", 32'(level), 0);
    chk("ovf_sticky", 32'(overflow), 1);

    // Reset mid-operation with three entries queued.
    evt_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cnt_in = seq3[i]; step();
    end
    chk("prerst_level", 32'(level), 3);
    chk("prerst_overflow", 32'(overflow), 1);
    rst = 1'b1; cnt_in = 4'd10; step();
    rst = 1'b0;
    chk("midrst_level", 32'(level), 0);
    chk("midrst_valid", 32'(evt_valid), 0);
    chk("midrst_overflow", 32'(overflow), 0);
    chk("midrst_type", 32'(evt_type), 0);
    chk("midrst_stamp", 32'(evt_stamp), 0);
    cnt_in = 4'd2; step();
    chk("first_sample_level", 32'(level), 0);
    chk("first_sample_valid", 32'(evt_valid), 0);
    cnt_in = 4'd3; step();
    cnt_in = 4'd9; step();
    chk("postrst_jump_valid", 32'(evt_valid), 1);
    chk("postrst_jump_type", 32'(evt_type), 3);
    chk("postrst_jump_stamp", 32'(evt_stamp), 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
